fft_pease_output_serializer: RTL and testbench

//  Consumer end of the Pease FFT output handshake. Accepts one whole spectrum frame
//  (N_SAMPLES parallel words) on a val/rdy port and streams it out one word per beat
//  on a val/rdy port, tagged with bin index and last-of-frame.
//  Two frame slots (ping-pong): the FFT can hand over frame k+1 while frame k drains.

---
 rtl/fft_pease_pkg.sv | 16 +
 rtl/fft_helpers_FrameSlot.sv | 27 ++
 rtl/fft_pease_output_serializer.sv | 125 ++++++++++++
 tb/tb_fft_pease_output_serializer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pease_pkg.sv
// Shared types for the Pease FFT frame serializer/deserializer pair:
// frame index width helper and the two-slot occupancy state.
package fft_pease_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    // Width of a bin index; clamped to 1 so a degenerate frame still has a legal vector.
    function automatic int frame_idx_w(input int n_samples);
        return (n_samples < 2) ? 1 : $clog2(n_samples);
    endfunction

endpackage

// File: rtl/fft_helpers_FrameSlot.sv
// One frame buffer: loads a whole spectrum frame in a single cycle, reads one word by bin index.
module fft_helpers_FrameSlot
    import fft_pease_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8,
    localparam int IDX_W    = frame_idx_w(N_SAMPLES)
) (
    input  logic                                clk,
    input  logic                                we_i,
    input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] wr_frame_i,
    input  logic [IDX_W-1:0]                    rd_idx_i,
    output logic [BIT_WIDTH-1:0]                rd_word_o
);

    // Contents survive reset; the occupancy FSM decides whether they are live.
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] frame_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            frame_q <= wr_frame_i;
        end
    end

    assign rd_word_o = frame_q[rd_idx_i];

endmodule

// File: rtl/fft_pease_output_serializer.sv
// Ping-pong frame buffer that takes whole FFT spectra and streams them out one bin per beat,
// tagged with bin index and last-of-frame.
module fft_pease_output_serializer
    import fft_pease_pkg::*;
#(
    parameter int BIT_WIDTH     = 32,
    parameter int N_SAMPLES     = 8,
    parameter int HALF_SPECTRUM = 0,
    localparam int IDX_W        = frame_idx_w(N_SAMPLES)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_msg,
    input  logic                                recv_val,
    output logic                                recv_rdy,
    output logic [BIT_WIDTH-1:0]                send_msg,
    output logic [IDX_W-1:0]                    send_idx,
    output logic                                send_last,
    output logic                                send_val,
    input  logic                                send_rdy
);

    localparam int              N_OUT    = (HALF_SPECTRUM != 0) ? N_SAMPLES / 2 : N_SAMPLES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    occ_e             state_q;
    logic             wr_sel_q;
    logic             rd_sel_q;
    logic [IDX_W-1:0] idx_q;
    logic             recv_rdy_q;
    logic             send_val_q;

    logic                 recv_fire;
    logic                 beat;
    logic                 at_last;
    logic                 last_beat;
    logic [1:0]           slot_we;
    logic [BIT_WIDTH-1:0] slot_word [2];

    assign recv_fire = recv_val && recv_rdy_q;
    assign beat      = send_val_q && send_rdy;
    assign at_last   = (idx_q == LAST_IDX);
    assign last_beat = beat && at_last;

    // Ping-pong guarantees slot[wr_sel] is never the slot being drained while occupied.
    for (genvar s = 0; s < 2; s++) begin : g_slot
        assign slot_we[s] = recv_fire && (wr_sel_q == 1'(s));

        fft_helpers_FrameSlot #(
            .BIT_WIDTH (BIT_WIDTH),
            .N_SAMPLES (N_SAMPLES)
        ) u_slot (
            .clk        (clk),
            .we_i       (slot_we[s]),
            .wr_frame_i (recv_msg),
            .rd_idx_i   (idx_q),
            .rd_word_o  (slot_word[s])
        );
    end

    // Handshake outputs are registered alongside the occupancy state, so neither
    // recv_rdy nor send_val has a combinational path from recv_val or send_rdy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= EMPTY;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            idx_q      <= '0;
            recv_rdy_q <= 1'b1;
            send_val_q <= 1'b0;
        end else begin
            if (recv_fire) begin
                wr_sel_q <= ~wr_sel_q;
            end
            if (beat) begin
                idx_q <= at_last ? '0 : idx_q + IDX_W'(1);
            end
            if (last_beat) begin
                rd_sel_q <= ~rd_sel_q;
            end

            case (state_q)
                EMPTY: begin
                    if (recv_fire) begin
                        state_q    <= ONE;
                        recv_rdy_q <= 1'b1;
                        send_val_q <= 1'b1;
                    end
                end
                ONE: begin
                    // Accept on the same edge as the last beat keeps occupancy at one.
                    if (recv_fire && !last_beat) begin
                        state_q    <= FULL;
                        recv_rdy_q <= 1'b0;
                        send_val_q <= 1'b1;
                    end else if (!recv_fire && last_beat) begin
                        state_q    <= EMPTY;
                        recv_rdy_q <= 1'b1;
                        send_val_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (last_beat) begin
                        state_q    <= ONE;
                        recv_rdy_q <= 1'b1;
                        send_val_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    recv_rdy_q <= 1'b1;
                    send_val_q <= 1'b0;
                end
            endcase
        end
    end

    assign recv_rdy  = recv_rdy_q;
    assign send_val  = send_val_q;
    assign send_idx  = idx_q;
    assign send_last = send_val_q && at_last;
    // Slots are not cleared on reset, so the word is forced to zero while idle.
    assign send_msg  = send_val_q ? slot_word[rd_sel_q] : '0;

endmodule

// File: tb/tb_fft_pease_output_serializer.sv
// Bench for the output serializer: full-spectrum and half-spectrum instances share stimulus,
// a frame-queue model checks every cycle, and directed scenarios pin literal beat sequences.
module tb_fft_pease_output_serializer;

    localparam int BW = 32;
    localparam int NS = 8;

    typedef logic [NS-1:0][BW-1:0] frame_t;
    typedef struct {
        logic [31:0] msg;
        int          idx;
        bit          last;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    frame_t      recv_msg = '0;
    logic        recv_val = 1'b0;
    logic        send_rdy = 1'b0;
    logic [1:0]  rrdy, sval, slast;
    logic [31:0] smsg [2];
    logic [2:0]  sidx [2];

    always #5 clk = ~clk;

    fft_pease_output_serializer #(.BIT_WIDTH(BW), .N_SAMPLES(NS), .HALF_SPECTRUM(0)) dut (
        .clk(clk), .reset(reset), .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(rrdy[0]),
        .send_msg(smsg[0]), .send_idx(sidx[0]), .send_last(slast[0]), .send_val(sval[0]),
        .send_rdy(send_rdy));

    fft_pease_output_serializer #(.BIT_WIDTH(BW), .N_SAMPLES(NS), .HALF_SPECTRUM(1)) dut_h (
        .clk(clk), .reset(reset), .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(rrdy[1]),
        .send_msg(smsg[1]), .send_idx(sidx[1]), .send_last(slast[1]), .send_val(sval[1]),
        .send_rdy(send_rdy));

    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    bit     model_on = 0;
    bit     just_rst = 0;
    frame_t mq [2][$];
    int     mpos [2];
    int     nout [2] = '{8, 4};
    beat_t  blog [2][$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic frame_t mk(input int base);
        frame_t f;
        for (int i = 0; i < NS; i++) f[i] = 32'(base + i);
        return f;
    endfunction

    // Model: each instance holds a queue of accepted frames (at most two) and a read position.
    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                mq[d].delete();
                mpos[d] = 0;
            end
            model_on = 1;
            just_rst = 1;
        end else if (model_on) begin
            just_rst = 0;
            for (int d = 0; d < 2; d++) begin
                bit snd, rcv;
                snd = (mq[d].size() > 0) && send_rdy;
                rcv = recv_val && (mq[d].size() < 2);
                if (sval[d] && send_rdy)
                    blog[d].push_back('{smsg[d], int'(sidx[d]), slast[d], cyc});
                if (snd) begin
                    if (mpos[d] == nout[d] - 1) begin
                        void'(mq[d].pop_front());
                        mpos[d] = 0;
                    end else begin
                        mpos[d]++;
                    end
                end
                if (rcv) mq[d].push_back(recv_msg);
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            for (int d = 0; d < 2; d++) begin
                bit ev;
                ev = mq[d].size() > 0;
                chk($sformatf("recv_rdy[%0d]", d), 64'(rrdy[d]), 64'(mq[d].size() < 2));
                chk($sformatf("send_val[%0d]", d), 64'(sval[d]), 64'(ev));
                if (ev) begin
                    chk($sformatf("send_msg[%0d]", d), 64'(smsg[d]), 64'(mq[d][0][mpos[d]]));
                    chk($sformatf("send_idx[%0d]", d), 64'(sidx[d]), 64'(mpos[d]));
                    chk($sformatf("send_last[%0d]", d), 64'(slast[d]), 64'(mpos[d] == nout[d] - 1));
                end else begin
                    chk($sformatf("idle_idx[%0d]", d), 64'(sidx[d]), 64'd0);
                    chk($sformatf("idle_last[%0d]", d), 64'(slast[d]), 64'd0);
                end
                if (just_rst) chk($sformatf("rst_msg[%0d]", d), 64'(smsg[d]), 64'd0);
            end
        end
    end

    task automatic drive_frame(input frame_t f, input bit keep);
        bit ok;
        ok = 0;
        @(negedge clk);
        #1 recv_msg = f;
        recv_val = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (rrdy[0]) begin
                ok = 1;
                break;
            end
        end
        chk("accept_timeout", 64'(ok), 64'd1);
        if (!keep) #1 recv_val = 1'b0;
    endtask

    task automatic wait_beats(input int d, input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (blog[d].size() >= n) begin
                ok = 1;
                break;
            end
        end
        chk("beat_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mq[0].size() == 0 && mq[1].size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("drain_timeout", 64'(ok), 64'd1);
    endtask

    task automatic clear_logs();
        blog[0].delete();
        blog[1].delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_rdy", 64'(rrdy[d]), 64'd1);
            chk("reset_val", 64'(sval[d]), 64'd0);
            chk("reset_idx", 64'(sidx[d]), 64'd0);
            chk("reset_last", 64'(slast[d]), 64'd0);
            chk("reset_msg", 64'(smsg[d]), 64'd0);
        end
        #1 reset = 1'b1;

        // 1: single frame, 1..8; half-spectrum instance emits 1..4
        clear_logs();
        #0 send_rdy = 1'b1;
        drive_frame(mk(1), 0);
        @(negedge clk);
        chk("t1_first_val", 64'(sval[0]), 64'd1);
        chk("t1_first_msg", 64'(smsg[0]), 64'd1);
        chk("t1_first_idx", 64'(sidx[0]), 64'd0);
        wait_beats(0, 8);
        repeat (2) @(negedge clk);
        chk("t1_val_after", 64'(sval[0]), 64'd0);
        chk("t1_nbeats", 64'(blog[0].size()), 64'd8);
        for (int i = 0; i < 8 && i < blog[0].size(); i++) begin
            chk("t1_msg", 64'(blog[0][i].msg), 64'(i + 1));
            chk("t1_idx", 64'(blog[0][i].idx), 64'(i));
            chk("t1_last", 64'(blog[0][i].last), 64'(i == 7));
        end
        // 5: half spectrum
        chk("t5_nbeats", 64'(blog[1].size()), 64'd4);
        for (int i = 0; i < 4 && i < blog[1].size(); i++) begin
            chk("t5_msg", 64'(blog[1][i].msg), 64'(i + 1));
            chk("t5_idx", 64'(blog[1][i].idx), 64'(i));
            chk("t5_last", 64'(blog[1][i].last), 64'(i == 3));
        end

        // 2: back-to-back frames with recv_val held high
        clear_logs();
        drive_frame(mk(32'h10), 1);
        drive_frame(mk(32'h20), 0);
        wait_beats(0, 16);
        for (int i = 0; i < 16; i++)
            chk("t2_msg", 64'(blog[0][i].msg), 64'((i < 8) ? 32'h10 + i : 32'h20 + i - 8));
        chk("t2_no_bubble", 64'(blog[0][15].cyc - blog[0][0].cyc), 64'd15);
        wait_drain();

        // 3: backpressure pattern 1,0,0,1
        clear_logs();
        #1 send_rdy = 1'b0;
        drive_frame(mk(32'h30), 0);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (blog[0].size() >= 8) break;
            #1 send_rdy = pat[k % 4];
        end
        chk("t3_nbeats", 64'(blog[0].size()), 64'd8);
        for (int i = 0; i < 8 && i < blog[0].size(); i++) begin
            chk("t3_msg", 64'(blog[0][i].msg), 64'(32'h30 + i));
            chk("t3_idx", 64'(blog[0][i].idx), 64'(i));
        end
        #1 send_rdy = 1'b1;
        wait_drain();

        // 4: fill both slots, third frame ignored
        clear_logs();
        #1 send_rdy = 1'b0;
        drive_frame(mk(32'h40), 0);
        drive_frame(mk(32'h60), 0);
        @(negedge clk);
        chk("t4_full_rdy", 64'(rrdy[0]), 64'd0);
        #1 recv_msg = mk(32'h70);
        recv_val = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t4_c_blocked", 64'(rrdy[0]), 64'd0);
        end
        #1 recv_val = 1'b0;
        send_rdy = 1'b1;
        wait_beats(0, 16);
        wait_drain();
        chk("t4_nbeats", 64'(blog[0].size()), 64'd16);
        for (int i = 0; i < 16 && i < blog[0].size(); i++)
            chk("t4_msg", 64'(blog[0][i].msg), 64'((i < 8) ? 32'h40 + i : 32'h60 + i - 8));

        // 6: reset mid-frame after beat 3
        clear_logs();
        drive_frame(mk(32'h80), 0);
        wait_beats(0, 3);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_val", 64'(sval[0]), 64'd0);
        chk("t6_rdy", 64'(rrdy[0]), 64'd1);
        chk("t6_idx", 64'(sidx[0]), 64'd0);
        #1 reset = 1'b1;
        clear_logs();
        drive_frame(mk(32'h90), 0);
        wait_beats(0, 8);
        for (int i = 0; i < 8; i++) begin
            chk("t6_msg", 64'(blog[0][i].msg), 64'(32'h90 + i));
            chk("t6_idx2", 64'(blog[0][i].idx), 64'(i));
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
